// File: rtl/aig_mix_in_loader.sv
// Beat-to-word loader for the AIG mix stage: packs NBEATS input beats (LSB chunk first)
// into one 80-bit word, flags short/long frames and counts errors and deliveries.
module aig_mix_in_loader #(
  parameter int CHUNK_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [CHUNK_W-1:0] s_data,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [79:0]        m_data,
  output logic               err_pulse,
  output logic [7:0]         err_cnt,
  output logic [15:0]        frame_cnt
);

  localparam int NBEATS = 80 / CHUNK_W;
  localparam int KW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NBEATS - 1);

  if ((80 % CHUNK_W) != 0) begin : g_bad_chunk
    $error("CHUNK_W must divide 80 evenly");
  end

  typedef enum logic [1:0] {
    COLLECT,
    FULL,
    DRAIN
  } state_t;

  state_t        state;
  logic [KW-1:0] k;
  logic          accept;
  logic [6:0]    base;

  assign accept = s_valid && s_ready;
  assign base   = 7'(k) * 7'(CHUNK_W);

  // s_ready and m_valid are registered alongside the state: m_valid is high exactly in
  // FULL and s_ready exactly outside it. Malformed frames pulse err_pulse for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      k         <= '0;
      s_ready   <= 1'b1;
      m_valid   <= 1'b0;
      m_data    <= '0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        COLLECT: begin
          if (accept) begin
            m_data[base +: CHUNK_W] <= s_data;
            if (k == KLAST) begin
              k <= '0;
              if (s_last) begin
                state   <= FULL;
                m_valid <= 1'b1;
                s_ready <= 1'b0;
              end else begin
                // long frame: the remaining beats up to s_last are swallowed in DRAIN
                state     <= DRAIN;
                err_pulse <= 1'b1;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
              end
            end else if (s_last) begin
              k         <= '0;
              err_pulse <= 1'b1;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        FULL: begin
          if (m_ready) begin
            state     <= COLLECT;
            m_valid   <= 1'b0;
            s_ready   <= 1'b1;
            frame_cnt <= frame_cnt + 16'd1;
          end
        end
        DRAIN: begin
          if (accept && s_last) state <= COLLECT;
        end
        default: begin
          state   <= COLLECT;
          k       <= '0;
          m_valid <= 1'b0;
          s_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aig_mix_in_loader.sv
// Scoreboard bench for aig_mix_in_loader: frames are modelled as whole beat lists, expected
// words are queued on issue and a monitor pops them on every output handshake.
module tb_aig_mix_in_loader;

  localparam int CW = 16;
  localparam int NB = 80 / CW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [CW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [79:0]   m_data;
  logic          err_pulse;
  logic [7:0]    err_cnt;
  logic [15:0]   frame_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [79:0] exp_q[$];
  logic [CW-1:0] beats[$];
  int          exp_err_total = 0;
  int          pulse_seen = 0;
  logic [15:0] exp_fc = '0;
  int          mr_mode = 0;

  aig_mix_in_loader #(.CHUNK_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // m_ready: random, held low, or held high depending on the current test phase
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (mr_mode)
        0:       m_ready = ($urandom_range(0, 3) != 0);
        1:       m_ready = 1'b0;
        default: m_ready = 1'b1;
      endcase
    end
  end

  // monitor: word scoreboard, hold stability, delivery count and pulse counting
  initial begin : monitor
    logic        prev_hold;
    logic [79:0] prev_data;
    prev_hold = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
        continue;
      end
      check("frame_cnt", frame_cnt, exp_fc);
      check("ready_vs_valid", s_ready, !m_valid);
      if (err_pulse) pulse_seen++;
      if (prev_hold) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got %0h, expected no word", m_data);
        end else begin
          check("m_data", m_data, exp_q.pop_front());
        end
        exp_fc++;
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  initial begin
    #(60000 * 10);
    $display("[TB] FAIL watchdog: got time limit, expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic sendBeat(input logic [CW-1:0] d, input logic last, input int gap);
    int   waited;
    logic rdy;
    waited  = 0;
    s_valid = 1'b0;
    repeat (gap) align();
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    forever begin
      @(negedge clk);
      rdy = s_ready;
      align();
      if (rdy) break;
      waited++;
      if (waited > 2000) begin
        checks++;
        errors++;
        $display("[TB] FAIL s_ready_timeout: got s_ready=0 for %0d cycles, expected 1", waited);
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic checkOutput();
    check("err_cnt", err_cnt, (exp_err_total > 255) ? 255 : exp_err_total);
    check("err_pulse_count", pulse_seen, exp_err_total);
  endtask

  task automatic fillBeats(input int len);
    beats.delete();
    for (int i = 0; i < len; i++) beats.push_back(CW'($urandom));
  endtask

  // Model: a frame of exactly NB beats is one word (beat i in chunk i); any other length is one error.
  task automatic applyStimulus(input int max_gap);
    int          len;
    logic [79:0] word;
    len  = beats.size();
    word = '0;
    if (len == NB) begin
      for (int i = 0; i < NB; i++) word[i*CW +: CW] = beats[i];
      exp_q.push_back(word);
    end else begin
      exp_err_total++;
    end
    for (int i = 0; i < len; i++) begin
      sendBeat(beats[i], i == len - 1, $urandom_range(0, max_gap));
      if (len > NB && i == NB - 1) begin
        @(negedge clk);
        check("long_err_pulse", err_pulse, 1);
        align();
      end
    end
    @(negedge clk);
    if (len == NB) begin
      check("latency_m_valid", m_valid, 1);
    end else if (len < NB) begin
      check("short_err_pulse", err_pulse, 1);
      check("short_no_valid", m_valid, 0);
    end else begin
      check("drain_no_err", err_pulse, 0);
    end
    #1;
    checkOutput();
    align();
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", exp_q.size(), 0);
    align();
  endtask

  task automatic doReset();
    rst_n         = 1'b0;
    exp_fc        = '0;
    exp_err_total = 0;
    pulse_seen    = 0;
    exp_q.delete();
    #1;
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 80'h0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    repeat (2) align();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [79:0] held;
    int          r;
    rst_n = 1'b1;
    #1;
    doReset();

    mr_mode = 2;
    beats.delete();
    for (int i = 1; i <= NB; i++) beats.push_back(CW'(i));
    applyStimulus(0);
    waitDrain();

    mr_mode = 1;
    fillBeats(NB);
    applyStimulus(0);
    held = m_data;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("bp_valid", m_valid, 1);
      check("bp_s_ready", s_ready, 0);
      check("bp_data", m_data, held);
    end
    mr_mode = 2;
    @(negedge clk);
    check("bp_handshake", m_valid && m_ready, 1);
    @(negedge clk);
    check("bp_ready_after", s_ready, 1);
    check("bp_valid_after", m_valid, 0);
    align();

    fillBeats(3);
    applyStimulus(0);
    fillBeats(NB);
    applyStimulus(0);
    waitDrain();

    fillBeats(7);
    applyStimulus(0);
    fillBeats(NB);
    applyStimulus(1);
    waitDrain();

    mr_mode = 0;
    for (int f = 0; f < 40; f++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      fillBeats(NB);
      else if (r < 8) fillBeats($urandom_range(1, NB - 1));
      else            fillBeats($urandom_range(NB + 1, NB + 3));
      applyStimulus(1);
    end
    waitDrain();

    sendBeat(CW'($urandom), 1'b0, 0);
    sendBeat(CW'($urandom), 1'b0, 0);
    doReset();
    fillBeats(NB);
    applyStimulus(0);
    waitDrain();

    mr_mode = 1;
    fillBeats(NB);
    applyStimulus(0);
    doReset();
    mr_mode = 0;
    fillBeats(NB);
    applyStimulus(0);
    waitDrain();

    for (int f = 0; f < 256; f++) begin
      fillBeats(1);
      applyStimulus(0);
    end
    check("err_cnt_saturated", err_cnt, 255);

    mr_mode = 2;
    @(posedge clk);
    #2;
    force dut.frame_cnt = 16'hFFFF;
    exp_fc = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    align();
    fillBeats(NB);
    applyStimulus(0);
    waitDrain();
    @(negedge clk);
    check("frame_cnt_wrap", frame_cnt, 0);
    align();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
